// File: rtl/spr_sharp_ctrl.sv
// Sequencer for the SPR sharpness-amount datapath: hs/vs/de tracking, shp_en/shp_sel generation,
// frame-latched config and amount-valid flagging. Optional line-length checker: SPR_SHARP_LEN_CHK_EN.
module spr_sharp_ctrl #(
    parameter int H_W       = 12,
    parameter int V_W       = 12,
    parameter int PIPE_LAT  = 4,
    parameter int BORDER_PX = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_hs,
    input  logic           i_vs,
    input  logic           i_de,
    input  logic           cfg_sharp_en,
    input  logic           cfg_sharp_prt,
    input  logic [H_W-1:0] cfg_h_active,
    output logic           o_hs,
    output logic           o_vs,
    output logic           shp_en,
    output logic           shp_sel,
    output logic           spr_sharp_prt,
    output logic           o_amt_vld,
    output logic [H_W-1:0] o_x,
    output logic [V_W-1:0] o_y,
    output logic           o_frame_start,
    output logic           o_len_err
);

    localparam int FW = $clog2(PIPE_LAT + 1);
    localparam logic [FW-1:0]  FILL_MAX = FW'(PIPE_LAT);
    localparam logic [H_W-1:0] LAT_H    = H_W'(PIPE_LAT);
    localparam logic [H_W:0]   BPX_W    = (H_W + 1)'(BORDER_PX);
    localparam logic [H_W:0]   BPX2_W   = (H_W + 1)'(2 * BORDER_PX);

    typedef enum logic [1:0] {S_IDLE, S_VBLANK, S_LINE, S_HBLANK} state_t;

    state_t         state, state_nxt;
    logic           hs_d, vs_d;
    logic [H_W-1:0] x_cnt, x_cnt_nxt, line_len_r, line_len_nxt;
    logic [FW-1:0]  fill, fill_nxt;
    logic [V_W-1:0] y_cnt, y_nxt;
    logic           en_shadow, prt_shadow;

    logic           vs_rise, hs_rise, hs_fall, line_start, in_line, pix, en_c, sel_c, vld_c;
    logic           frame_start_c, line_end_c;
    logic [H_W-1:0] x_eff;
    logic [FW-1:0]  fill_eff;
    logic [H_W:0]   x_w, len_w;

    // The hs-rise cycle already carries the first pixel, so the line is "live" before the state flips.
    always_comb begin
        vs_rise    = i_vs & ~vs_d;
        hs_rise    = i_hs & ~hs_d;
        hs_fall    = ~i_hs & hs_d;
        line_start = (state == S_VBLANK || state == S_HBLANK) && i_vs && hs_rise;
        in_line    = i_vs && i_hs && (state == S_LINE || line_start);
        x_eff      = line_start ? '0 : x_cnt;
        fill_eff   = line_start ? '0 : fill;
        pix        = in_line & i_de;
        en_c       = pix & en_shadow;
        x_w        = {1'b0, x_eff};
        len_w      = {1'b0, line_len_r};
        sel_c      = (len_w <= BPX2_W) || (x_w < BPX_W) || (x_w >= len_w - BPX_W);
        vld_c      = en_c && (fill_eff == FILL_MAX);
    end

    always_comb begin
        state_nxt     = state;
        x_cnt_nxt     = x_cnt;
        fill_nxt      = fill;
        line_len_nxt  = line_len_r;
        y_nxt         = y_cnt;
        frame_start_c = 1'b0;
        line_end_c    = 1'b0;
        if (!i_vs) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (vs_rise) begin
                    state_nxt     = S_VBLANK;
                    frame_start_c = 1'b1;
                    y_nxt         = '0;
                    line_len_nxt  = cfg_h_active;
                end
                S_VBLANK, S_HBLANK: if (hs_rise) state_nxt = S_LINE;
                S_LINE: if (hs_fall) begin
                    state_nxt    = S_HBLANK;
                    line_len_nxt = x_cnt;
                    y_nxt        = y_cnt + 1'b1;
                    line_end_c   = 1'b1;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
        if (in_line) begin
            x_cnt_nxt = (pix && x_eff != '1) ? x_eff + 1'b1 : x_eff;
            fill_nxt  = (en_c && fill_eff != FILL_MAX) ? fill_eff + 1'b1 : fill_eff;
        end
    end

    // vs_d resets high so a vs already high at reset release is not taken as a frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            hs_d          <= 1'b0;
            vs_d          <= 1'b1;
            x_cnt         <= '0;
            fill          <= '0;
            y_cnt         <= '0;
            line_len_r    <= cfg_h_active;
            en_shadow     <= 1'b0;
            prt_shadow    <= 1'b0;
            o_hs          <= 1'b0;
            o_vs          <= 1'b0;
            shp_en        <= 1'b0;
            shp_sel       <= 1'b0;
            o_amt_vld     <= 1'b0;
            o_x           <= '0;
            o_frame_start <= 1'b0;
        end else begin
            state         <= state_nxt;
            hs_d          <= i_hs;
            vs_d          <= i_vs;
            x_cnt         <= x_cnt_nxt;
            fill          <= fill_nxt;
            y_cnt         <= y_nxt;
            line_len_r    <= line_len_nxt;
            if (frame_start_c) begin
                en_shadow  <= cfg_sharp_en;
                prt_shadow <= cfg_sharp_prt;
            end
            o_hs          <= i_hs;
            o_vs          <= i_vs;
            shp_en        <= en_c;
            shp_sel       <= pix & sel_c;
            o_amt_vld     <= vld_c;
            o_x           <= vld_c ? x_eff - LAT_H : '0;
            o_frame_start <= frame_start_c;
        end
    end

    assign o_y           = y_cnt;
    assign spr_sharp_prt = prt_shadow;

`ifdef SPR_SHARP_LEN_CHK_EN
    logic len_err_r;
    always_ff @(posedge clk) begin
        if (rst || frame_start_c)                       len_err_r <= 1'b0;
        else if (line_end_c && x_cnt != cfg_h_active)   len_err_r <= 1'b1;
    end
    assign o_len_err = len_err_r;
`else
    assign o_len_err = 1'b0;
`endif

endmodule

// File: tb/tb_spr_sharp_ctrl.sv
// Scoreboard bench for spr_sharp_ctrl: expected per-pixel outputs are queued as pixels are driven
// and popped when shp_en appears at the output.
module tb_spr_sharp_ctrl;

    logic        clk, rst;
    logic        i_hs, i_vs, i_de;
    logic        cfg_sharp_en, cfg_sharp_prt;
    logic [11:0] cfg_h_active;
    logic        o_hs, o_vs, shp_en, shp_sel, spr_sharp_prt, o_amt_vld, o_frame_start, o_len_err;
    logic [11:0] o_x, o_y;

    spr_sharp_ctrl dut (
        .clk(clk), .rst(rst), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
        .cfg_sharp_en(cfg_sharp_en), .cfg_sharp_prt(cfg_sharp_prt), .cfg_h_active(cfg_h_active),
        .o_hs(o_hs), .o_vs(o_vs), .shp_en(shp_en), .shp_sel(shp_sel), .spr_sharp_prt(spr_sharp_prt),
        .o_amt_vld(o_amt_vld), .o_x(o_x), .o_y(o_y), .o_frame_start(o_frame_start), .o_len_err(o_len_err)
    );

    typedef struct { logic sel; logic vld; int x; int y; } exp_t;

    exp_t sb[$];
    exp_t em;
    int   n_chk = 0, n_fail = 0, vld_seen = 0;
    bit   mon_on = 0, exp_en = 1;
    logic exp_err;
    logic [11:0] ex, ey;

    initial clk = 0;
    always #5 clk = ~clk;

    always @(negedge clk) if (mon_on) begin
        if (o_amt_vld) vld_seen++;
        if (shp_en) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_shp_en: got shp_en=1 with no pending pixel, required 0 at %0t", $time);
            end else begin
                em = sb.pop_front();
                ex = em.x[11:0];
                ey = em.y[11:0];
                if (shp_sel !== em.sel || o_amt_vld !== em.vld || o_y !== ey ||
                    (em.vld && o_x !== ex)) begin
                    n_fail++;
                    $display("FAIL pixel: got sel=%b vld=%b x=%0d y=%0d, required sel=%b vld=%b x=%0d y=%0d at %0t",
                             shp_sel, o_amt_vld, o_x, o_y, em.sel, em.vld, ex, ey, $time);
                end
            end
        end else if (o_amt_vld !== 1'b0) begin
            n_chk++;
            n_fail++;
            $display("FAIL amt_vld_no_en: got o_amt_vld=%b, required 0 at %0t", o_amt_vld, $time);
        end
    end

    task automatic cyc(input logic hs, input logic vs, input logic de);
        @(negedge clk);
        i_hs = hs; i_vs = vs; i_de = de;
    endtask

    // vs low, vs rise, one more cycle: on return o_frame_start is visible
    task automatic frame_begin();
        cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 1, 0); cyc(0, 1, 0);
    endtask

    // One line of npix valid pixels (optionally de=1010..), then 3 cycles of hblank.
    task automatic run_line(input int npix, input bit gapped, input int len_prev, input int y);
        int k = 0;
        while (k < npix) begin
            cyc(1, 1, 1);
            if (exp_en)
                sb.push_back('{sel: (k < 2 || len_prev <= 4 || k >= len_prev - 2),
                               vld: (k >= 4), x: k - 4, y: y});
            k++;
            if (gapped && k < npix) cyc(1, 1, 0);
        end
        repeat (3) cyc(0, 1, 0);
    endtask

    task automatic drain(input string name);
        repeat (2) cyc(0, i_vs, 0);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing: got %0d pixels never seen on shp_en, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1; i_hs = 0; i_vs = 0; i_de = 0;
        cfg_sharp_en = 1; cfg_sharp_prt = 0; cfg_h_active = 12'd10;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({o_hs, o_vs, shp_en, shp_sel, spr_sharp_prt, o_amt_vld, o_frame_start, o_len_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 00000000",
                     {o_hs, o_vs, shp_en, shp_sel, spr_sharp_prt, o_amt_vld, o_frame_start, o_len_err});
        end
        n_chk++;
        if (o_x !== 12'd0 || o_y !== 12'd0) begin
            n_fail++; $display("FAIL reset_xy: got x=%0d y=%0d, required 0 0", o_x, o_y);
        end
        @(negedge clk); rst = 0;
        mon_on = 1;
    endtask

    task automatic test_frame();
        vld_seen = 0;
        frame_begin();
        n_chk++;
        if (o_frame_start !== 1'b1) begin
            n_fail++; $display("FAIL frame_start: got %b, required 1", o_frame_start);
        end
        cyc(0, 1, 0);
        n_chk++;
        if (o_frame_start !== 1'b0) begin
            n_fail++; $display("FAIL frame_start_pulse: got %b, required 0", o_frame_start);
        end
        for (int l = 0; l < 3; l++) run_line(10, 0, 10, l);
        drain("frame");
        n_chk++;
        if (vld_seen != 18) begin
            n_fail++; $display("FAIL frame_vld_count: got %0d, required 18", vld_seen);
        end
        n_chk++;
        if (o_y !== 12'd3) begin
            n_fail++; $display("FAIL frame_lines: got o_y=%0d, required 3", o_y);
        end
    endtask

    task automatic test_prt();
        cfg_sharp_prt = 0;
        frame_begin();
        run_line(10, 0, 10, 0);
        cfg_sharp_prt = 1;
        run_line(10, 0, 10, 1);
        n_chk++;
        if (spr_sharp_prt !== 1'b0) begin
            n_fail++; $display("FAIL prt_midframe: got %b, required 0", spr_sharp_prt);
        end
        drain("prt");
        frame_begin();
        n_chk++;
        if (o_frame_start !== 1'b1 || spr_sharp_prt !== 1'b1) begin
            n_fail++;
            $display("FAIL prt_next_frame: got fs=%b prt=%b, required 1 1", o_frame_start, spr_sharp_prt);
        end
    endtask

    task automatic test_gap();
        vld_seen = 0;
        frame_begin();
        run_line(8, 1, 10, 0);
        drain("gap");
        n_chk++;
        if (vld_seen != 4) begin
            n_fail++; $display("FAIL gap_vld_count: got %0d, required 4", vld_seen);
        end
    endtask

    task automatic test_vs_drop();
        frame_begin();
        run_line(10, 0, 10, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1, 1);
            sb.push_back('{sel: (k < 2), vld: (k >= 4), x: k - 4, y: 1});
        end
        cyc(1, 0, 1); cyc(1, 0, 1); cyc(0, 0, 0);
        drain("vs_drop");
        n_chk++;
        if (o_y !== 12'd1) begin
            n_fail++; $display("FAIL vs_drop_y: got o_y=%0d, required 1", o_y);
        end
        frame_begin();
        n_chk++;
        if (o_y !== 12'd0) begin
            n_fail++; $display("FAIL vs_drop_new_frame_y: got o_y=%0d, required 0", o_y);
        end
        run_line(10, 0, 10, 0);
        drain("vs_drop_next");
    endtask

    task automatic test_short();
        vld_seen = 0;
        frame_begin();
        run_line(3, 0, 10, 0);
        run_line(3, 0, 3, 1);
        run_line(3, 0, 3, 2);
        drain("short");
        n_chk++;
        if (vld_seen != 0) begin
            n_fail++; $display("FAIL short_vld: got %0d, required 0", vld_seen);
        end
    endtask

    task automatic test_len_err();
`ifdef SPR_SHARP_LEN_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        frame_begin();
        run_line(10, 0, 10, 0);
        n_chk++;
        if (o_len_err !== 1'b0) begin
            n_fail++; $display("FAIL len_err_good_line: got %b, required 0", o_len_err);
        end
        run_line(9, 0, 10, 1);
        n_chk++;
        if (o_len_err !== exp_err) begin
            n_fail++; $display("FAIL len_err_short_line: got %b, required %b", o_len_err, exp_err);
        end
        run_line(10, 0, 9, 2);
        n_chk++;
        if (o_len_err !== exp_err) begin
            n_fail++; $display("FAIL len_err_sticky: got %b, required %b", o_len_err, exp_err);
        end
        drain("len_err");
        frame_begin();
        n_chk++;
        if (o_len_err !== 1'b0) begin
            n_fail++; $display("FAIL len_err_clear: got %b, required 0", o_len_err);
        end
    endtask

    task automatic test_sharp_dis();
        cfg_sharp_en = 0;
        exp_en = 0;
        frame_begin();
        run_line(10, 0, 10, 0);
        cfg_sharp_en = 1;
        run_line(10, 0, 10, 1);
        drain("sharp_dis");
        exp_en = 1;
    endtask

    task automatic test_rst_mid_line();
        frame_begin();
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 1);
            sb.push_back('{sel: (k < 2), vld: 1'b0, x: 0, y: 0});
        end
        cyc(1, 1, 1); rst = 1;
        cyc(1, 1, 1); cyc(1, 1, 1); rst = 0;
        repeat (6) cyc(1, 1, 1);
        n_chk++;
        if (o_y !== 12'd0 || o_x !== 12'd0) begin
            n_fail++; $display("FAIL rst_mid_xy: got x=%0d y=%0d, required 0 0", o_x, o_y);
        end
        cyc(0, 1, 0);
        drain("rst_mid");
        frame_begin();
        run_line(10, 0, 10, 0);
        drain("rst_restart");
    endtask

    initial begin
        test_reset();
        test_frame();
        test_prt();
        test_gap();
        test_vs_drop();
        test_short();
        test_len_err();
        test_sharp_dis();
        test_rst_mid_line();
        mon_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
